// File: rtl/ahb_lite_decoder_mux.sv
// ----------------------------------------------------------------------------
// ahb_lite_decoder_mux
//
// AHB-Lite address decoder and slave response multiplexer sitting between the
// Cortex-M0 master port and up to four slaves (ROM, SRAM, GPIO, UART).
//
//   * Address phase: HSEL_S0..S3 decoded combinationally from HADDR.
//     Unmapped addresses raise an internal default-slave select.
//   * Data phase: a one-hot select register {DEF,S3,S2,S1,S0} captured while
//     HREADY is high steers HRDATA/HREADY/HRESP back to the master. HREADY
//     is also the system ready fanned out to every slave.
//   * Default slave: answers active transfers to unmapped space with a
//     two-cycle ERROR (HREADY 0/1, HRESP 1/1). IDLE/BUSY get zero-wait OKAY.
//
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HADDR, HTRANS            master address-phase signals
//   HSEL_S0..HSEL_S3         slave selects (not qualified by HTRANS)
//   HRDATA_Sx/HREADYOUT_Sx/HRESP_Sx   slave responses
//   HREADY, HRDATA, HRESP    multiplexed response to the master
//   o_dbg_state              default-slave FSM state (IDLE=0, ERR1=1, ERR2=2)
//   o_dbg_dsel               data-phase select register {DEF,S3,S2,S1,S0}
//
// Handshake: a transfer's address phase is accepted on a rising HCLK edge
// where HREADY = 1; its data phase completes on the first later edge where
// HREADY = 1. HREADY = 0 stalls both the data phase and the next address.
// ----------------------------------------------------------------------------
module ahb_lite_decoder_mux #(
    parameter logic [31:0] ADDR_MASK = 32'hFF00_0000,
    parameter logic [31:0] S0_BASE   = 32'h0000_0000,
    parameter logic [31:0] S1_BASE   = 32'h2000_0000,
    parameter logic [31:0] S2_BASE   = 32'h4000_0000,
    parameter logic [31:0] S3_BASE   = 32'h4100_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HSEL_S0,
    output logic        HSEL_S1,
    output logic        HSEL_S2,
    output logic        HSEL_S3,
    input  logic [31:0] HRDATA_S0,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,
    input  logic [31:0] HRDATA_S3,
    input  logic        HREADYOUT_S0,
    input  logic        HREADYOUT_S1,
    input  logic        HREADYOUT_S2,
    input  logic        HREADYOUT_S3,
    input  logic        HRESP_S0,
    input  logic        HRESP_S1,
    input  logic        HRESP_S2,
    input  logic        HRESP_S3,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [1:0]  o_dbg_state,
    output logic [4:0]  o_dbg_dsel
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [31:0] w_addr_masked;
    logic [3:0]  w_dec;
    logic        w_sel_def;
    logic        w_active;
    logic        w_unused;

    logic [4:0]  r_dsel;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_def_hready;
    logic        w_def_hresp;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign w_unused = HTRANS[0];
    assign w_active = HTRANS[1];

    // ------------------------------------------------------------------
    // Address decode: purely from HADDR, so no path from any HREADYOUT.
    // ------------------------------------------------------------------
    assign w_addr_masked = HADDR & ADDR_MASK;
    assign w_dec[0]      = (w_addr_masked == S0_BASE);
    assign w_dec[1]      = (w_addr_masked == S1_BASE);
    assign w_dec[2]      = (w_addr_masked == S2_BASE);
    assign w_dec[3]      = (w_addr_masked == S3_BASE);
    assign w_sel_def     = ~|w_dec;

    assign HSEL_S0 = w_dec[0];
    assign HSEL_S1 = w_dec[1];
    assign HSEL_S2 = w_dec[2];
    assign HSEL_S3 = w_dec[3];

    // ------------------------------------------------------------------
    // Data-phase select: follows the address phase only when it is
    // accepted, so a stalled slave keeps ownership of the response mux.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel <= 5'b0_0000;
        end else if (HREADY) begin
            r_dsel <= {w_sel_def, w_dec};
        end
    end

    // ------------------------------------------------------------------
    // Default slave FSM. It tracks every unmapped active transfer whether
    // or not its output is currently routed; its outputs are only visible
    // to the master when r_dsel selects DEF.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (HREADY && w_sel_def && w_active) begin
                    w_state_nxt = ST_ERR1;
                end
            end
            // Address phase is stalled here, so decode is deliberately ignored.
            ST_ERR1: w_state_nxt = ST_ERR2;
            ST_ERR2: begin
                if (w_sel_def && w_active) begin
                    w_state_nxt = ST_ERR1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_def_hready = (r_state != ST_ERR1);
    assign w_def_hresp  = (r_state == ST_ERR1) || (r_state == ST_ERR2);

    // ------------------------------------------------------------------
    // Response mux. An all-zero select (after reset) gives zero-wait OKAY.
    // ------------------------------------------------------------------
    always_comb begin
        HREADY = 1'b1;
        HRDATA = 32'h0000_0000;
        HRESP  = 1'b0;
        case (r_dsel)
            5'b0_0001: begin
                HREADY = HREADYOUT_S0;
                HRDATA = HRDATA_S0;
                HRESP  = HRESP_S0;
            end
            5'b0_0010: begin
                HREADY = HREADYOUT_S1;
                HRDATA = HRDATA_S1;
                HRESP  = HRESP_S1;
            end
            5'b0_0100: begin
                HREADY = HREADYOUT_S2;
                HRDATA = HRDATA_S2;
                HRESP  = HRESP_S2;
            end
            5'b0_1000: begin
                HREADY = HREADYOUT_S3;
                HRDATA = HRDATA_S3;
                HRESP  = HRESP_S3;
            end
            5'b1_0000: begin
                HREADY = w_def_hready;
                HRDATA = 32'h0000_0000;
                HRESP  = w_def_hresp;
            end
            default: begin
                HREADY = 1'b1;
                HRDATA = 32'h0000_0000;
                HRESP  = 1'b0;
            end
        endcase
    end

    assign o_dbg_state = r_state;
    assign o_dbg_dsel  = r_dsel;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_decoder_mux
//
// Directed bench for ahb_lite_decoder_mux. Inputs change 1 ns after each
// rising HCLK edge; outputs are sampled 1 ns after that, well clear of the
// next edge. Each scenario task carries its own hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_ahb_lite_decoder_mux;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'hA5A5_0003;
    localparam logic [31:0] D3 = 32'h3333_0004;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3;
    logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
    logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
    logic        HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [1:0]  o_dbg_state;
    logic [4:0]  o_dbg_dsel;

    int vecs = 0;
    int errs = 0;

    ahb_lite_decoder_mux dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSEL_S0(HSEL_S0), .HSEL_S1(HSEL_S1), .HSEL_S2(HSEL_S2), .HSEL_S3(HSEL_S3),
        .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1),
        .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
        .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1),
        .HREADYOUT_S2(HREADYOUT_S2), .HREADYOUT_S3(HREADYOUT_S3),
        .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1),
        .HRESP_S2(HRESP_S2), .HRESP_S3(HRESP_S3),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
        .o_dbg_state(o_dbg_state), .o_dbg_dsel(o_dbg_dsel)
    );

    // ---------------- clock / reset ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance to 1 ns after the next rising edge.
    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    // Drive an address phase, then let combinational outputs settle.
    task automatic drive(input logic [31:0] addr, input logic [1:0] trans);
        HADDR  = addr;
        HTRANS = trans;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        HRESETn = 1'b0;
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL reset_outputs: got rdy/resp/data %b/%b/%h want 1/0/00000000", HREADY, HRESP, HRDATA);
        end
        vecs++;
        if ({o_dbg_dsel, o_dbg_state} !== 7'b00000_00) begin
            errs++;
            $display("FAIL reset_state: got dsel/state %b/%0d want 00000/0", o_dbg_dsel, o_dbg_state);
        end
        next_cycle();
        next_cycle();
        HRESETn = 1'b1;
        next_cycle();
    endtask

    task automatic test_gpio_read();
        drive(32'h4000_0004, 2'b10);
        vecs++;
        if ({HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0} !== 4'b0100) begin
            errs++;
            $display("FAIL gpio_hsel_addr: got %b want 0100", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0});
        end
        next_cycle();
        drive(32'h7000_0000, 2'b00);
        vecs++;
        if ({HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0} !== 4'b0000) begin
            errs++;
            $display("FAIL gpio_hsel_data: got %b want 0000", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0});
        end
        vecs++;
        if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, D2}) begin
            errs++;
            $display("FAIL gpio_data: got rdy/resp/data %b/%b/%h want 1/0/%h", HREADY, HRESP, HRDATA, D2);
        end
    endtask

    // Continues from test_gpio_read: an IDLE transfer to 0x7000_0000 is in its address phase.
    task automatic test_idle_unmapped();
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL idle_unmapped: got rdy/resp/data %b/%b/%h want 1/0/00000000", HREADY, HRESP, HRDATA);
        end
        vecs++;
        if ({o_dbg_dsel, o_dbg_state} !== 7'b10000_00) begin
            errs++;
            $display("FAIL idle_unmapped_state: got dsel/state %b/%0d want 10000/0", o_dbg_dsel, o_dbg_state);
        end
        next_cycle();
    endtask

    task automatic test_wait_states();
        drive(32'h2000_0010, 2'b10);
        vecs++;
        if ({HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0} !== 4'b0010) begin
            errs++;
            $display("FAIL ws_hsel: got %b want 0010", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0});
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            HREADYOUT_S1 = 1'b0;
            drive(32'h4000_0000, 2'b10);
            vecs++;
            if ({HREADY, o_dbg_dsel, HSEL_S2} !== {1'b0, 5'b00010, 1'b1}) begin
                errs++;
                $display("FAIL ws_stall%0d: got rdy/dsel/hsel2 %b/%b/%b want 0/00010/1", i, HREADY, o_dbg_dsel, HSEL_S2);
            end
        end
        next_cycle();
        HREADYOUT_S1 = 1'b1;
        drive(32'h4000_0000, 2'b10);
        vecs++;
        if ({HREADY, HRESP, HRDATA, o_dbg_dsel} !== {1'b1, 1'b0, D1, 5'b00010}) begin
            errs++;
            $display("FAIL ws_done: got rdy/resp/data/dsel %b/%b/%h/%b want 1/0/%h/00010", HREADY, HRESP, HRDATA, o_dbg_dsel, D1);
        end
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRDATA, o_dbg_dsel} !== {1'b1, D2, 5'b00100}) begin
            errs++;
            $display("FAIL ws_next: got rdy/data/dsel %b/%h/%b want 1/%h/00100", HREADY, HRDATA, o_dbg_dsel, D2);
        end
        next_cycle();
    endtask

    task automatic test_slave_error();
        drive(32'h4100_0000, 2'b10);
        vecs++;
        if ({HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0} !== 4'b1000) begin
            errs++;
            $display("FAIL serr_hsel: got %b want 1000", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0});
        end
        next_cycle();
        HREADYOUT_S3 = 1'b0;
        HRESP_S3     = 1'b1;
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, o_dbg_dsel} !== {1'b0, 1'b1, 5'b01000}) begin
            errs++;
            $display("FAIL serr_c1: got rdy/resp/dsel %b/%b/%b want 0/1/01000", HREADY, HRESP, o_dbg_dsel);
        end
        next_cycle();
        HREADYOUT_S3 = 1'b1;
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, HRDATA, o_dbg_dsel} !== {1'b1, 1'b1, D3, 5'b01000}) begin
            errs++;
            $display("FAIL serr_c2: got rdy/resp/data/dsel %b/%b/%h/%b want 1/1/%h/01000", HREADY, HRESP, HRDATA, o_dbg_dsel, D3);
        end
        next_cycle();
        HRESP_S3 = 1'b0;
    endtask

    task automatic test_unmapped();
        drive(32'h6000_0000, 2'b10);
        vecs++;
        if ({HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0} !== 4'b0000) begin
            errs++;
            $display("FAIL unm_hsel: got %b want 0000", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0});
        end
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, HRDATA, o_dbg_state} !== {1'b0, 1'b1, 32'h0, 2'd1}) begin
            errs++;
            $display("FAIL unm_err1: got rdy/resp/data/state %b/%b/%h/%0d want 0/1/00000000/1", HREADY, HRESP, HRDATA, o_dbg_state);
        end
        next_cycle();
        drive(32'h0000_0000, 2'b10);
        vecs++;
        if ({HREADY, HRESP, o_dbg_state} !== {1'b1, 1'b1, 2'd2}) begin
            errs++;
            $display("FAIL unm_err2: got rdy/resp/state %b/%b/%0d want 1/1/2", HREADY, HRESP, o_dbg_state);
        end
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, HRDATA, o_dbg_state} !== {1'b1, 1'b0, D0, 2'd0}) begin
            errs++;
            $display("FAIL unm_then_rom: got rdy/resp/data/state %b/%b/%h/%0d want 1/0/%h/0", HREADY, HRESP, HRDATA, o_dbg_state, D0);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy;
        exp_rdy = 4'b1010; // data-phase HREADY sequence 0,1,0,1 (LSB first)
        drive(32'h6000_0000, 2'b10);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            // ERR1 of the first error: master goes IDLE, which must be ignored.
            // ERR2 of the first error: the SEQ to 0x6000_0004 is presented.
            if (i == 0)      drive(32'h6000_0004, 2'b00);
            else if (i == 1) drive(32'h6000_0004, 2'b11);
            else             drive(32'h0000_0000, 2'b00);
            vecs++;
            if ({HREADY, HRESP} !== {exp_rdy[i], 1'b1}) begin
                errs++;
                $display("FAIL b2b_cycle%0d: got rdy/resp %b/%b want %b/1", i, HREADY, HRESP, exp_rdy[i]);
            end
        end
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, o_dbg_state} !== {1'b1, 1'b0, 2'd0}) begin
            errs++;
            $display("FAIL b2b_end: got rdy/resp/state %b/%b/%0d want 1/0/0", HREADY, HRESP, o_dbg_state);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_err();
        drive(32'h6000_0000, 2'b10);
        next_cycle();
        drive(32'h6000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, o_dbg_state} !== {1'b0, 1'b1, 2'd1}) begin
            errs++;
            $display("FAIL rst_pre_err1: got rdy/resp/state %b/%b/%0d want 0/1/1", HREADY, HRESP, o_dbg_state);
        end
        #1;
        HRESETn = 1'b0;
        #1;
        vecs++;
        if ({HREADY, HRESP, HRDATA, o_dbg_dsel, o_dbg_state} !== {1'b1, 1'b0, 32'h0, 5'b00000, 2'd0}) begin
            errs++;
            $display("FAIL rst_async: got rdy/resp/data/dsel/state %b/%b/%h/%b/%0d want 1/0/00000000/00000/0", HREADY, HRESP, HRDATA, o_dbg_dsel, o_dbg_state);
        end
        next_cycle();
        vecs++;
        if ({HREADY, HRESP, HRDATA, o_dbg_dsel} !== {1'b1, 1'b0, 32'h0, 5'b00000}) begin
            errs++;
            $display("FAIL rst_held: got rdy/resp/data/dsel %b/%b/%h/%b want 1/0/00000000/00000", HREADY, HRESP, HRDATA, o_dbg_dsel);
        end
        HRESETn = 1'b1;
        drive(32'h0000_0000, 2'b10);
        vecs++;
        if ({HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0} !== 4'b0001) begin
            errs++;
            $display("FAIL rst_post_hsel: got %b want 0001", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0});
        end
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        vecs++;
        if ({HREADY, HRESP, HRDATA, o_dbg_dsel} !== {1'b1, 1'b0, D0, 5'b00001}) begin
            errs++;
            $display("FAIL rst_post_read: got rdy/resp/data/dsel %b/%b/%h/%b want 1/0/%h/00001", HREADY, HRESP, HRDATA, o_dbg_dsel, D0);
        end
        next_cycle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        HRDATA_S0 = D0;
        HRDATA_S1 = D1;
        HRDATA_S2 = D2;
        HRDATA_S3 = D3;
        {HREADYOUT_S3, HREADYOUT_S2, HREADYOUT_S1, HREADYOUT_S0} = 4'b1111;
        {HRESP_S3, HRESP_S2, HRESP_S1, HRESP_S0} = 4'b0000;
        HADDR  = 32'h0;
        HTRANS = 2'b00;

        test_reset();
        test_gpio_read();
        test_idle_unmapped();
        test_wait_states();
        test_slave_error();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_err();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Global time bound so a stuck run still ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no end of sequence want finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ahb_lite_decoder_mux.md
Name: ahb_lite_decoder_mux

Overview:
- AHB-Lite address decoder and slave response multiplexer between the Cortex-M0 master port and up to four peripheral slaves, e.g. ROM, RAM, the GPIO slave and a UART.
- Generates per-slave HSEL from the address phase.
- Registers the data-phase slave selection and routes HRDATA/HREADY/HRESP back to the master and to all slaves as system HREADY.
- Contains a built-in default slave that returns a two-cycle ERROR response for accesses to unmapped addresses.

Parameters:
- ADDR_MASK, 32'hFF00_0000, bits of HADDR compared during decode.
- S0_BASE, 32'h0000_0000, region base of slave 0 (code ROM).
- S1_BASE, 32'h2000_0000, region base of slave 1 (SRAM).
- S2_BASE, 32'h4000_0000, region base of slave 2 (GPIO).
- S3_BASE, 32'h4100_0000, region base of slave 3 (UART).

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HSEL_S0..HSEL_S3  out  1 each  slave selects
- HRDATA_S0..HRDATA_S3  in  32 each  slave read data
- HREADYOUT_S0..HREADYOUT_S3  in  1 each  slave ready
- HRESP_S0..HRESP_S3  in  1 each  slave response (1 = ERROR)
- HREADY  out  1  system ready to master and all slaves
- HRDATA  out  32  read data to master
- HRESP  out  1  response to master

Interface: reset HRESETn, asynchronous, active-low; clock HCLK. All registers reset asynchronously on HRESETn low and update on posedge HCLK.

Behaviour:
- Address decode (combinational):
  - HSEL_Si = ((HADDR & ADDR_MASK) == Si_BASE), independent of HTRANS; slaves qualify with HTRANS[1].
  - At most one HSEL_Si is high; base collisions are a configuration error and are not checked.
  - No match -> internal sel_def = 1.
- Data-phase select register dsel, 5-bit one-hot {DEF,S3..S0}:
  - Loads the decoded address-phase select when HREADY = 1; holds when HREADY = 0.
  - Reset value is all-zero (no slave).
- Response mux:
  - dsel = Si -> HREADY = HREADYOUT_Si, HRDATA = HRDATA_Si, HRESP = HRESP_Si.
  - dsel = DEF -> outputs come from the default slave.
  - dsel all-zero -> HREADY = 1, HRDATA = 0, HRESP = 0.
- Default slave FSM, states IDLE, ERR1, ERR2; reset to IDLE:
  - IDLE:
    - Outputs HREADY = 1, HRESP = 0, HRDATA = 0.
    - If HREADY = 1, sel_def = 1 and HTRANS[1] = 1 (NONSEQ/SEQ), go to ERR1; else stay.
  - ERR1:
    - Outputs HREADY = 0, HRESP = 1.
    - Always go to ERR2. The address phase is stalled, so decode is not sampled.
  - ERR2:
    - Outputs HREADY = 1, HRESP = 1.
    - If sel_def = 1 and HTRANS[1] = 1, go to ERR1 (back-to-back error); else go to IDLE.
  - IDLE/BUSY transfers to unmapped space get a zero-wait OKAY and the FSM stays in IDLE.
- FSM outputs reach the master only when dsel = DEF. FSM transitions track sel_def and HTRANS regardless of dsel.
- Latency:
  - Mapped slave: the slave's own wait states; the mux adds zero cycles.
  - Unmapped active transfer: exactly 2 data-phase cycles.
- Slave-side errors: a slave's two-cycle ERROR passes through unmodified; dsel holds through the HREADY = 0 cycle.
- Master may change HTRANS to IDLE during ERR1; the change is ignored until ERR2 samples it.
- Reset mid-transfer: FSM returns to IDLE, dsel clears, HREADY = 1 and HRESP = 0 immediately (asynchronous).
- No combinational path from HREADYOUT_Si to HSEL_Si.

Test Plan:
- Reset check: assert HRESETn low mid-ERR1 -> HREADY = 1, HRESP = 0, HRDATA = 0 while reset is low; dsel all-zero; first transfer after release decodes normally.
- Read of GPIO: NONSEQ read at 0x4000_0004, HRDATA_S2 = 0xA5A5_0003, HREADYOUT_S2 = 1 -> HSEL_S2 = 1 in the address phase only; next cycle HRDATA = 0xA5A5_0003, HREADY = 1, HRESP = 0.
- Wait-state pass-through: read of 0x2000_0010 with HREADYOUT_S1 low for 3 cycles -> HREADY low 3 cycles; next address (0x4000_0000) is held, and dsel stays S1 until HREADY = 1.
- Unmapped access: NONSEQ write to 0x6000_0000 -> data phase gives HREADY/HRESP = 0/1 then 1/1, then IDLE; a following read of 0x0000_0000 returns HRDATA_S0 with OKAY.
- Back-to-back unmapped: NONSEQ at 0x6000_0000 then SEQ at 0x6000_0004 presented in ERR2 -> two consecutive ERR1/ERR2 pairs (HREADY pattern 0,1,0,1; HRESP high 4 cycles).
- IDLE to unmapped: HTRANS = IDLE, HADDR = 0x7000_0000 -> FSM stays IDLE; data phase HREADY = 1, HRESP = 0, HRDATA = 0.
